// File: rtl/seg7_pkg.sv
// Seven-segment encodings and digit-select definitions shared by the
// seconds/minutes/hours display stages.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Anode enables are active-low: an[0] drives units, an[1] drives tens.
    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    // Wide enough for the largest scan period (65535 cycles).
    localparam int CNT_W = 16;

    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_TENS  = 1'b1
    } dig_sel_e;

    function automatic logic [1:0] an_for(input dig_sel_e sel);
        return (sel == DIG_TENS) ? AN_TENS : AN_UNITS;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder with blanking; non-BCD codes
// show a dash so a corrupted digit is visible rather than misleading.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seconds_tens_display.sv
// Tens-of-seconds digit (mod 6) with minute carry, plus a two-digit
// multiplexed seven-segment driver showing tens:units.
//
// select    | meaning
// DIG_UNITS | units digit driven, an = 2'b10
// DIG_TENS  | tens digit driven,  an = 2'b01
module seconds_tens_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic [3:0] units,
    input  logic       units_eq_9,
    input  logic       clear,
    output logic [2:0] tens,
    output logic       minute_pulse,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt;
    dig_sel_e         sel;
    logic             advance;
    logic             scan_wrap;
    logic [3:0]       dec_digit;
    logic             dec_blank;
    logic [6:0]       seg_next;

    assign advance   = inc & units_eq_9;
    assign scan_wrap = (scan_cnt == SCAN_LAST);

    // Clear wins over an advance, so a clear on 59 never emits a carry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tens         <= 3'd0;
            minute_pulse <= 1'b0;
        end else if (clear) begin
            tens         <= 3'd0;
            minute_pulse <= 1'b0;
        end else if (advance) begin
            tens         <= (tens == 3'd5) ? 3'd0 : tens + 3'd1;
            minute_pulse <= (tens == 3'd5);
        end else begin
            minute_pulse <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            sel      <= DIG_UNITS;
        end else if (clear) begin
            scan_cnt <= '0;
            sel      <= DIG_UNITS;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            sel      <= (sel == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        dec_digit = units;
        dec_blank = 1'b0;
        if (sel == DIG_TENS) begin
            dec_digit = {1'b0, tens};
            dec_blank = BLANK_LZ && (tens == 3'd0);
        end
    end

    seg7_decode u_decode (
        .digit (dec_digit),
        .blank (dec_blank),
        .seg   (seg_next)
    );

    // Anode stays driven while blanked so the scan duty cycle is unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next;
            an  <= an_for(sel);
        end
    end

endmodule
